// File: rtl/inst_sram_axi_bridge_if.sv
// AXI4 read-address and read-data channels between the instruction fetch bridge
// and the memory interconnect.
// Handshake rule for every channel: a beat transfers on a rising clk edge where
// valid && ready; a master holds valid and its payload stable until that edge.
interface inst_sram_axi_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-SRAM responder: turns a 64-bit dual-instruction fetch into a one-
// or two-beat AXI4 INCR read burst and stalls the fetch stage until data returns.
module inst_sram_axi_bridge #(
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic        flush,
  output logic [63:0] inst_sram_rdata,
  output logic        inst_sram_ok2,
  output logic        inst_sram_err,
  output logic        inst_stall,
  inst_sram_axi_bridge_if.master axi,
  output logic [2:0]  dbg_state,
  output logic        rsp_anomaly
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R0    = 3'd2,
    S_R1    = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t      state;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [31:0] data_lo;
  logic [31:0] data_hi;
  logic        ok2_q;
  logic        err_q;
  logic [1:0]  beats_left;
  logic        flushed;

  logic r_hs;
  logic resp_err;
  logic id_bad;
  logic last_bad;
  logic single_beat;

  assign r_hs        = axi.rvalid && rready_q;
  assign resp_err    = (axi.rresp != 2'b00);
  assign id_bad      = (axi.rid != ID_W'(AXI_ID));
  assign last_bad    = (axi.rlast != (beats_left == 2'd1));
  // The upper word would sit in the next 4KB page, so fetch only one word.
  assign single_beat = (inst_sram_addr[11:2] == 10'h3FF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      data_lo     <= '0;
      data_hi     <= '0;
      ok2_q       <= 1'b0;
      err_q       <= 1'b0;
      beats_left  <= '0;
      flushed     <= 1'b0;
      rsp_anomaly <= 1'b0;
    end else begin
      rsp_anomaly <= r_hs && (id_bad || last_bad);
      if (r_hs) beats_left <= beats_left - 2'd1;
      case (state)
        S_IDLE: begin
          if (inst_sram_en && !flush) begin
            araddr_q   <= inst_sram_addr;
            arlen_q    <= single_beat ? 8'd0 : 8'd1;
            beats_left <= single_beat ? 2'd1 : 2'd2;
            arvalid_q  <= 1'b1;
            flushed    <= 1'b0;
            state      <= S_AR;
          end
        end
        S_AR: begin
          if (flush) flushed <= 1'b1;
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= (flushed || flush) ? S_DRAIN : S_R0;
          end
        end
        S_R0, S_R1: begin
          if (flush) begin
            // Redirected: the burst must still be consumed, but nothing is delivered.
            state <= S_DRAIN;
            if (r_hs && beats_left == 2'd1) begin
              rready_q <= 1'b0;
              state    <= S_IDLE;
            end
          end else if (r_hs) begin
            if (state == S_R0) begin
              data_lo <= axi.rdata;
              err_q   <= resp_err;
              if (arlen_q[0]) begin
                state <= S_R1;
              end else begin
                data_hi  <= '0;
                ok2_q    <= 1'b0;
                rready_q <= 1'b0;
                state    <= S_DONE;
              end
            end else begin
              data_hi  <= axi.rdata;
              err_q    <= err_q | resp_err;
              ok2_q    <= 1'b1;
              rready_q <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        S_DRAIN: begin
          if (r_hs && beats_left == 2'd1) begin
            rready_q <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inst_sram_rdata = err_q ? 64'd0 : {data_hi, data_lo};
  assign inst_sram_ok2   = ok2_q && !err_q;
  assign inst_sram_err   = err_q;
  assign inst_stall      = inst_sram_en && (state != S_DONE);

  assign axi.arid    = ID_W'(AXI_ID);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: AXI memory responder, spec-level fetch
// model feeding expected queues, and a per-cycle compare process.
module tb_inst_sram_axi_bridge;
  localparam int ID_W   = 4;
  localparam int AXI_ID = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en;
  logic        flush;
  logic [31:0] addr;
  logic [63:0] rdata_o;
  logic        ok2;
  logic        err;
  logic        stall;
  logic [2:0]  dbg_state;
  logic        anomaly;

  inst_sram_axi_bridge_if #(.ID_W(ID_W)) axi_if ();

  inst_sram_axi_bridge #(.AXI_ID(AXI_ID), .ID_W(ID_W)) dut (
    .clk             (clk),
    .resetn          (rst_n),
    .inst_sram_en    (en),
    .inst_sram_addr  (addr),
    .flush           (flush),
    .inst_sram_rdata (rdata_o),
    .inst_sram_ok2   (ok2),
    .inst_sram_err   (err),
    .inst_stall      (stall),
    .axi             (axi_if),
    .dbg_state       (dbg_state),
    .rsp_anomaly     (anomaly)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [65:0] exp_q[$];     // {err, ok2, rdata} per delivered fetch
  logic [39:0] exp_ar_q[$];  // {arlen, araddr} per AR handshake
  logic [31:0] src_d[$];
  logic [1:0]  src_r[$];
  logic [31:0] pend_d[$];
  logic [1:0]  pend_r[$];
  int              ar_delay = 0;
  bit              tog_mode = 1'b0;
  bit              phase = 1'b1;
  logic [ID_W-1:0] cur_rid = '0;
  int              wait_cnt = 0;
  int              slv_n = 0;
  bit              seen_anomaly = 1'b0;
  bit              ar_hold = 1'b0;
  logic [31:0]     held_addr = '0;
  logic [65:0]     exp_e;
  logic [39:0]     exp_a;
  int              cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  // Fetch model: a page-end address gets one beat; any error response zeroes the result.
  function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] d0, d1,
                                        input logic [1:0] r0, r1);
    bit one = (a[11:2] == 10'h3FF);
    bit e   = (r0 != 2'b00) || (!one && r1 != 2'b00);
    logic [63:0] d = e ? 64'd0 : {one ? 32'd0 : d1, d0};
    return {e, !one && !e, d};
  endfunction

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] d0, d1,
                            input logic [1:0] r0, r1, input bit deliver);
    bit one = (a[11:2] == 10'h3FF);
    src_d.push_back(d0);
    src_r.push_back(r0);
    if (!one) begin
      src_d.push_back(d1);
      src_r.push_back(r1);
    end
    exp_ar_q.push_back({one ? 8'd0 : 8'd1, a});
    if (deliver) exp_q.push_back(model(a, d0, d1, r0, r1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int c);
    bit got = 1'b0;
    c = 0;
    while (!got && c < 200) begin
      @(negedge clk);
      if (!stall) got = 1'b1;
      else c++;
    end
    if (!got) fail("done_timeout");
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d0, d1,
                          input logic [1:0] r0, r1, output int c);
    push_fetch(a, d0, d1, r0, r1, 1'b1);
    en   = 1'b1;
    addr = a;
    wait_done(c);
  endtask

  task automatic end_fetch();
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // ---------------- AXI memory responder ----------------
  initial begin
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = '0;
    axi_if.rlast   = 1'b0;
    axi_if.rid     = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend_d.delete();
        pend_r.delete();
        wait_cnt = 0;
      end else begin
        if (axi_if.arvalid && axi_if.arready) begin
          slv_n = int'(axi_if.arlen) + 1;
          for (int i = 0; i < slv_n; i++) begin
            if (src_d.size() > 0) begin
              pend_d.push_back(src_d.pop_front());
              pend_r.push_back(src_r.pop_front());
            end
          end
        end
        if (axi_if.rvalid && axi_if.rready && pend_d.size() > 0) begin
          void'(pend_d.pop_front());
          void'(pend_r.pop_front());
        end
      end
      #1;
      if (rst_n && axi_if.arvalid) begin
        axi_if.arready = (wait_cnt >= ar_delay);
        wait_cnt++;
      end else begin
        axi_if.arready = 1'b0;
        wait_cnt = 0;
      end
      if (rst_n && pend_d.size() > 0) begin
        axi_if.rvalid = tog_mode ? phase : 1'b1;
        phase         = !phase;
        axi_if.rdata  = pend_d[0];
        axi_if.rresp  = pend_r[0];
        axi_if.rlast  = (pend_d.size() == 1);
        axi_if.rid    = cur_rid;
      end else begin
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      ar_hold = 1'b0;
    end else begin
      if (!en) check("stall_without_en", {63'd0, stall}, 64'd0);
      if (en && !stall) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          exp_e = exp_q.pop_front();
          check("done_rdata", rdata_o, exp_e[63:0]);
          check("done_ok2", {63'd0, ok2}, {63'd0, exp_e[64]});
          check("done_err", {63'd0, err}, {63'd0, exp_e[65]});
        end
      end
      if (ar_hold) begin
        check("arvalid_held", {63'd0, axi_if.arvalid}, 64'd1);
        check("araddr_held", {32'd0, axi_if.araddr}, {32'd0, held_addr});
      end
      if (axi_if.arvalid && axi_if.arready) begin
        if (exp_ar_q.size() == 0) begin
          fail("unexpected_ar");
        end else begin
          exp_a = exp_ar_q.pop_front();
          check("araddr", {32'd0, axi_if.araddr}, {32'd0, exp_a[31:0]});
          check("arlen", {56'd0, axi_if.arlen}, {56'd0, exp_a[39:32]});
          check("arsize", {61'd0, axi_if.arsize}, 64'd2);
          check("arburst", {62'd0, axi_if.arburst}, 64'd1);
          check("arid", {60'd0, axi_if.arid}, 64'(AXI_ID));
        end
      end
      ar_hold   = axi_if.arvalid && !axi_if.arready;
      held_addr = axi_if.araddr;
      if (anomaly) seen_anomaly = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    addr  = '0;
    #12;
    check("rst_arvalid", {63'd0, axi_if.arvalid}, 64'd0);
    check("rst_rready", {63'd0, axi_if.rready}, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_ok2_err", {62'd0, ok2, err}, 64'd0);
    check("rst_araddr_arlen", {24'd0, axi_if.arlen, axi_if.araddr}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back two-beat fetch at minimum latency.
    do_fetch(32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00, cyc);
    check("t1_stall_cycles", 64'(cyc), 64'd4);
    check("t1_rdata", rdata_o, 64'h2222_2222_1111_1111);
    check("t1_ok2", {63'd0, ok2}, 64'd1);
    check("t1_arlen", {56'd0, axi_if.arlen}, 64'd1);
    check("t1_no_anomaly", {63'd0, seen_anomaly}, 64'd0);
    end_fetch();

    // Last word of a 4KB page: single beat, upper word invalid.
    do_fetch(32'h0000_0FFC, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 2'b00, 2'b00, cyc);
    check("t2_rdata", rdata_o, 64'h0000_0000_AAAA_AAAA);
    check("t2_ok2", {63'd0, ok2}, 64'd0);
    check("t2_arlen", {56'd0, axi_if.arlen}, 64'd0);
    end_fetch();

    // Slow AR acceptance and gappy R channel.
    ar_delay = 3;
    tog_mode = 1'b1;
    phase    = 1'b1;
    do_fetch(32'h0000_1230, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 2'b00, 2'b00, cyc);
    check("t3_stall_cycles", 64'(cyc), 64'd8);
    check("t3_rdata", rdata_o, 64'hA5A5_A5A5_5A5A_5A5A);
    end_fetch();
    ar_delay = 0;
    tog_mode = 1'b0;

    // Error on the second beat, then a clean fetch clears it.
    do_fetch(32'h0000_4000, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b10, cyc);
    check("t4_err", {63'd0, err}, 64'd1);
    check("t4_rdata", rdata_o, 64'd0);
    check("t4_ok2", {63'd0, ok2}, 64'd0);
    end_fetch();
    do_fetch(32'h0000_4008, 32'h5555_5555, 32'h6666_6666, 2'b00, 2'b00, cyc);
    check("t5_err", {63'd0, err}, 64'd0);
    check("t5_rdata", rdata_o, 64'h6666_6666_5555_5555);
    end_fetch();

    // Foreign rid is still accepted and flagged.
    cur_rid      = 4'd5;
    seen_anomaly = 1'b0;
    do_fetch(32'h0000_5000, 32'h7777_7777, 32'h8888_8888, 2'b00, 2'b00, cyc);
    check("t6_rdata", rdata_o, 64'h8888_8888_7777_7777);
    check("t6_anomaly", {63'd0, seen_anomaly}, 64'd1);
    end_fetch();
    cur_rid = '0;

    // Flush in IDLE keeps the request from starting.
    en    = 1'b1;
    flush = 1'b1;
    addr  = 32'h0000_6000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_no_arvalid", {63'd0, axi_if.arvalid}, 64'd0);
      check("t7_stall", {63'd0, stall}, 64'd1);
    end
    @(posedge clk);
    #1;
    en    = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;

    // Flush during R0 with an immediate redirect.
    push_fetch(32'h0000_3000, 32'hDEAD_0001, 32'hDEAD_0002, 2'b00, 2'b00, 1'b0);
    en   = 1'b1;
    addr = 32'h0000_3000;
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    addr  = 32'h8000_0100;
    push_fetch(32'h8000_0100, 32'hCAFE_0001, 32'hCAFE_0002, 2'b00, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_done(cyc);
    check("t8_stall_cycles", 64'(cyc), 64'd5);
    check("t8_rdata", rdata_o, 64'hCAFE_0002_CAFE_0001);
    end_fetch();

    // Asynchronous reset in the middle of R1.
    push_fetch(32'h0000_2000, 32'h9999_9999, 32'hBBBB_BBBB, 2'b00, 2'b00, 1'b0);
    en   = 1'b1;
    addr = 32'h0000_2000;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("t9_arvalid", {63'd0, axi_if.arvalid}, 64'd0);
    check("t9_rready", {63'd0, axi_if.rready}, 64'd0);
    check("t9_stall", {63'd0, stall}, 64'd0);
    check("t9_rdata", rdata_o, 64'd0);
    check("t9_ok2_err", {62'd0, ok2, err}, 64'd0);
    src_d.delete();
    src_r.delete();
    exp_ar_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_fetch(32'h0000_7000, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 2'b00, cyc);
    check("t9_after_cycles", 64'(cyc), 64'd4);
    check("t9_after_rdata", rdata_o, 64'h9ABC_DEF0_1234_5678);
    end_fetch();

    repeat (3) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
